// File: rtl/food_order_arbiter.sv
// food_order_arbiter
//   Shares one vending core between two customer ports. Requests are granted
//   round-robin, one transaction at a time. Each transaction is either issued
//   to the core or rejected locally. A hung core is aborted after VEND_TIMEOUT
//   wait cycles. The result is returned to the granted port with a one-cycle
//   ack.
//
//   Optional feature: define FOOD_ARB_STOCK_EN to compile in per-item stock
//   counters, out-of-stock rejection and the stock_empty flags. Without it,
//   stock_empty is tied to zero and STOCK_INIT has no effect.
//
// Parameters
//   VEND_TIMEOUT  max WAIT cycles before abort (1..255)
//   STOCK_INIT    per-item stock after reset (0..15), stock build only
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_a/b, choice_a/b, money_a/b  customer requests (held until ack)
//   ack_a/b                       one-cycle completion pulse to the port
//   item_out, change_out          result, updated in the ack cycle and held
//   vend_start                    one-cycle start pulse to the core
//   vend_choice, vend_money       granted transaction, held ISSUE..WAIT
//   vend_done, vend_item, vend_change  core completion and result
//   busy                          high whenever the FSM is not IDLE
//   stock_empty                   bit i-1 set when item i stock is zero
//
// States
//   IDLE    | waiting for a request; grants and latches the order
//   ISSUE   | pulses vend_start, clears the wait counter
//   WAIT    | waiting for vend_done or timeout
//   RESPOND | acks the granted port with item/change
module food_order_arbiter #(
  parameter int VEND_TIMEOUT = 15,
  parameter int STOCK_INIT   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [2:0] choice_a,
  input  logic [2:0] choice_b,
  input  logic [2:0] money_a,
  input  logic [2:0] money_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic [2:0] item_out,
  output logic [2:0] change_out,
  output logic       vend_start,
  output logic [2:0] vend_choice,
  output logic [2:0] vend_money,
  input  logic       vend_done,
  input  logic [2:0] vend_item,
  input  logic [2:0] vend_change,
  output logic       busy,
  output logic [3:0] stock_empty
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(VEND_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       last_b;     // last granted port (1 = B); also the current grant
  logic [7:0] wait_cnt;

  logic       any_req;
  logic       pick_b;
  logic [2:0] sel_choice;
  logic [2:0] sel_money;
  logic [1:0] sel_idx;
  logic       choice_ok;
  logic       in_stock;
  logic       accept;
  logic       timeout;

  assign any_req    = req_a | req_b;
  // Tie goes to the port that was not granted last.
  assign pick_b     = req_b & (~req_a | ~last_b);
  assign sel_choice = pick_b ? choice_b : choice_a;
  assign sel_money  = pick_b ? money_b  : money_a;
  assign sel_idx    = 2'(sel_choice - 3'd1);
  assign choice_ok  = (sel_choice >= 3'd1) && (sel_choice <= 3'd4);
  assign accept     = choice_ok & in_stock;
  assign timeout    = (wait_cnt == WAIT_LAST);

  assign busy  = (state != IDLE);
  assign ack_a = (state == RESPOND) & ~last_b;
  assign ack_b = (state == RESPOND) &  last_b;

  always_comb begin
    state_nxt  = state;
    vend_start = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = accept ? ISSUE : RESPOND;
      end
      ISSUE: begin
        vend_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (vend_done || timeout) state_nxt = RESPOND;
      end
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_b      <= 1'b1;
      wait_cnt    <= 8'd0;
      vend_choice <= 3'd0;
      vend_money  <= 3'd0;
      item_out    <= 3'd0;
      change_out  <= 3'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            last_b      <= pick_b;
            vend_choice <= sel_choice;
            vend_money  <= sel_money;
            if (!accept) begin
              item_out   <= 3'd0;
              change_out <= sel_money;
            end
          end
        end
        ISSUE: wait_cnt <= 8'd0;
        WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          // A done arriving on the timeout cycle still counts as a result.
          if (vend_done) begin
            item_out   <= vend_item;
            change_out <= vend_change;
          end else if (timeout) begin
            item_out   <= 3'd0;
            change_out <= vend_money;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FOOD_ARB_STOCK_EN
  logic [3:0] stock [4];
  logic [1:0] done_idx;
  logic       done_item_ok;

  assign done_idx     = 2'(vend_item - 3'd1);
  assign done_item_ok = (vend_item >= 3'd1) && (vend_item <= 3'd4);
  assign in_stock     = (stock[sel_idx] != 4'd0);

  // Only a real core completion consumes stock; aborts and rejects do not.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) stock[i] <= 4'(STOCK_INIT);
    end else if ((state == WAIT) && vend_done && done_item_ok &&
                 (stock[done_idx] != 4'd0)) begin
      stock[done_idx] <= stock[done_idx] - 4'd1;
    end
  end

  always_comb begin
    stock_empty = 4'b0000;
    for (int i = 0; i < 4; i++) stock_empty[i] = (stock[i] == 4'd0);
  end
`else
  assign in_stock    = 1'b1;
  assign stock_empty = 4'b0000;
`endif

endmodule

// File: tb/tb_food_order_arbiter.sv
module tb_food_order_arbiter;
  localparam int VEND_TIMEOUT = 15;
  localparam int STOCK_INIT   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [2:0] choice_a = 3'd0, choice_b = 3'd0;
  logic [2:0] money_a = 3'd0, money_b = 3'd0;
  logic       ack_a, ack_b;
  logic [2:0] item_out, change_out;
  logic       vend_start;
  logic [2:0] vend_choice, vend_money;
  logic       vend_done = 1'b0;
  logic [2:0] vend_item = 3'd0, vend_change = 3'd0;
  logic       busy;
  logic [3:0] stock_empty;

  food_order_arbiter #(.VEND_TIMEOUT(VEND_TIMEOUT), .STOCK_INIT(STOCK_INIT)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b),
    .choice_a(choice_a), .choice_b(choice_b),
    .money_a(money_a), .money_b(money_b),
    .ack_a(ack_a), .ack_b(ack_b),
    .item_out(item_out), .change_out(change_out),
    .vend_start(vend_start), .vend_choice(vend_choice), .vend_money(vend_money),
    .vend_done(vend_done), .vend_item(vend_item), .vend_change(vend_change),
    .busy(busy), .stock_empty(stock_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       port_b;
    logic [2:0] item;
    logic [2:0] change;
    int         lat;     // cycles after the request cycle; -1 = unchecked
  } ack_exp_t;

  typedef struct {
    logic [2:0] choice;
    logic [2:0] money;
  } vend_exp_t;

  ack_exp_t  ack_q[$];
  vend_exp_t vend_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Core model knobs: core_delay = cycles from vend_start to vend_done
  // (0 = silent core); core_echo returns item = choice, change = money - 1.
  int         core_delay = 1;
  bit         core_echo  = 1'b0;
  logic [2:0] core_item  = 3'd0;
  logic [2:0] core_change = 3'd0;
  int         rearm_a = 0, rearm_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_ack(input logic pb, input logic [2:0] it, input logic [2:0] ch, input int lat);
    ack_exp_t e;
    e.port_b = pb; e.item = it; e.change = ch; e.lat = lat;
    ack_q.push_back(e);
  endtask

  task automatic push_vend(input logic [2:0] ch, input logic [2:0] m);
    vend_exp_t v;
    v.choice = ch; v.money = m;
    vend_q.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; vend_done = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Called #1 after an edge with requests already driven. Plays the core,
  // drops/re-raises requests around acks, and scores every ack/vend_start.
  task automatic run(input int budget);
    int        c = 0;
    int        s = -1;
    bit        drop_a = 0, drop_b = 0, raise_a = 0, raise_b = 0;
    ack_exp_t  e;
    vend_exp_t v;
    while (ack_q.size() > 0 && c < budget) begin
      @(posedge clk); #1; c++;
      if (raise_a) begin req_a = 1'b1; raise_a = 0; end
      if (raise_b) begin req_b = 1'b1; raise_b = 0; end
      if (drop_a) begin
        req_a = 1'b0; drop_a = 0;
        if (rearm_a > 0) begin rearm_a--; raise_a = 1; end
      end
      if (drop_b) begin
        req_b = 1'b0; drop_b = 0;
        if (rearm_b > 0) begin rearm_b--; raise_b = 1; end
      end
      vend_done   = (core_delay > 0) && (s >= 0) && (c == s + core_delay);
      vend_item   = core_echo ? vend_choice : core_item;
      vend_change = core_echo ? vend_money - 3'd1 : core_change;
      @(negedge clk);
      if (vend_start) begin
        s = c;
        check("vend_start_expected", vend_q.size() != 0, 1);
        if (vend_q.size() != 0) begin
          v = vend_q.pop_front();
          check("vend_choice", vend_choice, v.choice);
          check("vend_money", vend_money, v.money);
        end
      end
      if (ack_a || ack_b) begin
        check("ack_not_both", ack_a & ack_b, 0);
        e = ack_q.pop_front();
        check("ack_port", ack_b, e.port_b);
        check("item_out", item_out, e.item);
        check("change_out", change_out, e.change);
        if (e.lat >= 0) check("ack_latency", c, e.lat);
        if (ack_a) drop_a = 1;
        if (ack_b) drop_b = 1;
      end
    end
    check("acks_outstanding", ack_q.size(), 0);
    check("vends_outstanding", vend_q.size(), 0);
    ack_q.delete();
    vend_q.delete();
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0; vend_done = 1'b0;
    rearm_a = 0; rearm_b = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_ack", {ack_a, ack_b}, 0);
    check("rst_vend_start", vend_start, 0);
    check("rst_busy", busy, 0);
    check("rst_item_change", {item_out, change_out}, 0);
    check("rst_vend_bus", {vend_choice, vend_money}, 0);
    check("rst_stock_empty", stock_empty, 0);
    @(posedge clk); #1;

    // Single order on A: done 3 cycles after vend_start.
    req_a = 1'b1; choice_a = 3'd1; money_a = 3'd7;
    core_delay = 3; core_echo = 0; core_item = 3'd1; core_change = 3'd4;
    push_vend(3'd1, 3'd7);
    push_ack(1'b0, 3'd1, 3'd4, 5);
    run(30);

    // Timeout on B with a silent core.
    req_b = 1'b1; choice_b = 3'd3; money_b = 3'd5;
    core_delay = 0;
    push_vend(3'd3, 3'd5);
    push_ack(1'b1, 3'd0, 3'd5, VEND_TIMEOUT + 2);
    run(40);
    // Late vend_done while IDLE must be ignored.
    vend_done = 1'b1; vend_item = 3'd2; vend_change = 3'd6;
    @(negedge clk);
    check("late_done_busy", busy, 0);
    @(posedge clk); #1; vend_done = 1'b0;
    @(negedge clk);
    check("late_done_quiet", {ack_a, ack_b, vend_start, busy}, 0);
    check("late_done_result", {item_out, change_out}, {3'd0, 3'd5});
    @(posedge clk); #1;

    // Done on the very timeout cycle wins over the abort.
    req_a = 1'b1; choice_a = 3'd4; money_a = 3'd6;
    core_delay = VEND_TIMEOUT; core_echo = 0; core_item = 3'd4; core_change = 3'd2;
    push_vend(3'd4, 3'd6);
    push_ack(1'b0, 3'd4, 3'd2, VEND_TIMEOUT + 2);
    run(40);

    // Invalid choice: immediate refund, no vend.
    req_a = 1'b1; choice_a = 3'd6; money_a = 3'd5;
    push_ack(1'b0, 3'd0, 3'd5, 1);
    run(10);

    // Arbitration from reset: both ports held and re-raised.
    do_reset();
    req_a = 1'b1; choice_a = 3'd1; money_a = 3'd3;
    req_b = 1'b1; choice_b = 3'd3; money_b = 3'd4;
    rearm_a = 1; rearm_b = 1;
    core_delay = 1; core_echo = 1;
    push_vend(3'd1, 3'd3); push_ack(1'b0, 3'd1, 3'd2, 3);
    push_vend(3'd3, 3'd4); push_ack(1'b1, 3'd3, 3'd3, -1);
    push_vend(3'd1, 3'd3); push_ack(1'b0, 3'd1, 3'd2, -1);
    push_vend(3'd3, 3'd4); push_ack(1'b1, 3'd3, 3'd3, -1);
    run(60);
    @(negedge clk);
`ifdef FOOD_ARB_STOCK_EN
    check("arb_stock_empty", stock_empty, 4'b0101);
`else
    check("arb_stock_empty", stock_empty, 4'b0000);
`endif

    // Stock: three orders of item 2 with STOCK_INIT = 2.
    do_reset();
    core_delay = 1; core_echo = 0; core_item = 3'd2; core_change = 3'd3;
    for (int k = 0; k < 3; k++) begin
      req_a = 1'b1; choice_a = 3'd2; money_a = 3'd7;
`ifdef FOOD_ARB_STOCK_EN
      if (k < 2) begin
        push_vend(3'd2, 3'd7); push_ack(1'b0, 3'd2, 3'd3, 3);
      end else begin
        push_ack(1'b0, 3'd0, 3'd7, 1);
      end
`else
      push_vend(3'd2, 3'd7); push_ack(1'b0, 3'd2, 3'd3, 3);
`endif
      run(20);
    end
    @(negedge clk);
`ifdef FOOD_ARB_STOCK_EN
    check("stock_empty_after", stock_empty, 4'b0010);
`else
    check("stock_empty_after", stock_empty, 4'b0000);
`endif
    @(posedge clk); #1;

    // Reset while WAITing: transaction dropped, everything back to reset.
    req_a = 1'b1; choice_a = 3'd1; money_a = 3'd4;
    core_delay = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rw_vend_start", vend_start, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; req_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("rw_quiet", {ack_a, ack_b, vend_start, busy}, 0);
    end
    check("rw_outputs", {item_out, change_out, vend_choice, vend_money}, 0);
    check("rw_stock_empty", stock_empty, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
